c_fetch: RTL and testbench
==========================

# c_fetch

Instruction-fetch front stage for the compressed-extension frontend. Owns the halfword-aligned fetch PC, issues word-aligned requests to instruction memory over a req/gnt/rvalid handshake, and presents one fetched 32-bit word plus its PC to the compressed realign/decode stage (`c_top`). It consumes that stage's `pc_half_o`, `stall_o` and `pc_realigned_o` to choose the next fetch address, and handles branch redirects, including killing an in-flight request.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset; bit 0 is ignored and treated as 0.
- NOP_INSTR, 32'h0000_0013, value driven on `instr_o` when no valid word is held.
- clk  input  1  core clock; all state changes on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- br_taken_i  input  1  branch/jump redirect request.
- br_target_i  input  32  redirect target; bit 0 is forced to 0.
- ext_stall_i  input  1  downstream pipeline hazard; the held word is not consumed.
- pc_half_i  input  1  from `c_top pc_half_o`: the current instruction is 16-bit.
- stall_i  input  1  from `c_top stall_o`: the next fetch must use `pc_realigned_i`.
- pc_realigned_i  input  32  from `c_top pc_realigned_o`.
- imem_req_o  output  1  memory request.
- imem_addr_o  output  32  request address; always word aligned, {fetch_addr_q[31:2],2'b00}.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid.
- imem_rdata_i  input  32  response word.
- pc_o  output  32  PC of the held word, halfword aligned; feeds `c_top pc_i`.
- instr_o  output  32  held word; feeds `c_top instr_i`.
- valid_o  output  1  `pc_o`/`instr_o` hold a live fetched word.

## Operation
- Registers: fetch_addr_q[31:0], pc_o, instr_o, valid_o, kill_q, and the state register.
- FSM states: IDLE, REQ, WAIT, DELIVER.
- IDLE:
  - Entered on reset; lasts one cycle.
  - Goes to REQ.
  - If br_taken_i is high, fetch_addr_q <= target.
- REQ:
  - imem_req_o=1.
  - On imem_gnt_i, go to WAIT.
  - If br_taken_i is high before the grant, fetch_addr_q <= target and stay in REQ. The address may change while ungranted.
  - If br_taken_i and imem_gnt_i occur in the same cycle, the old address is granted: go to WAIT with kill_q=1 and fetch_addr_q <= target.
- WAIT:
  - imem_req_o=0.
  - imem_rvalid_i is accepted only in this state; it is ignored in every other state.
  - On rvalid with kill_q=1: discard the data, clear kill_q, go to REQ.
  - On rvalid with kill_q=0: instr_o <= rdata, pc_o <= fetch_addr_q, valid_o <= 1, go to DELIVER.
  - br_taken_i in WAIT: kill_q <= 1, fetch_addr_q <= target.
- DELIVER:
  - valid_o=1 and the word is held.
  - Consumption occurs when ~ext_stall_i. Then next = stall_i ? pc_realigned_i : pc_o + (pc_half_i ? 2 : 4).
  - imem_req_o=1 with imem_addr_o derived from next in the same cycle (combinational). fetch_addr_q <= next.
  - If imem_gnt_i, go to WAIT; otherwise go to REQ.
  - valid_o clears on leaving DELIVER.
- Next-address priority in DELIVER: br_taken_i > ext_stall_i > stall_i > pc_half_i > +4.
- br_taken_i in DELIVER:
  - Redirects to the target and drops valid_o next cycle.
  - The held word is not consumed.
  - The request goes out next cycle from REQ.
- Arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- The PC is kept to bit 1 granularity. When pc_o[1]=1, the word requested is {pc[31:2],2'b00}; `c_top` extracts the upper half.

## Timing
- Reset values: state=IDLE, fetch_addr_q=RESET_PC&~1, pc_o=RESET_PC&~1, instr_o=NOP_INSTR, valid_o=0, kill_q=0, imem_req_o=0.
- First request is at cycle 1 after reset deasserts.
- Minimum latency is 1 cycle from grant to rvalid.
- Zero-wait memory (gnt same cycle, rvalid next) gives 1 word per 2 cycles, with valid_o toggling 1,0,1,0.
- Reset asserted mid-request:
  - Returns to IDLE next edge.
  - A late rvalid from the abandoned request arrives outside WAIT, or before the new grant, and is dropped.
  - The memory system must not return an rvalid for an abandoned request after a new grant.
- ext_stall_i held in DELIVER holds pc_o, instr_o and valid_o indefinitely with imem_req_o=0.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0093 at address 0: req at cycle 1, valid_o=1 at cycle 3 with pc_o=0. With pc_half_i=0 the next req goes to addr 4.
- pc_half_i=1 on a word at PC 0x100: next pc_o=0x102 and imem_addr_o=0x100. Then pc_half_i=0 gives pc_o=0x106 and imem_addr_o=0x104.
- stall_i=1 with pc_realigned_i=0x204 at PC 0x202: next imem_addr_o=0x204.
- br_taken_i with target 0x8001 while in WAIT: the rvalid word is dropped (valid_o stays 0), the next request goes to addr 0x8000, and pc_o=0x8000.
- br_taken_i in the same cycle as imem_gnt_i: exactly one discarded response, then a fetch from the target.
- ext_stall_i high for 5 cycles in DELIVER: outputs are stable and there is no req. Reset pulse during WAIT followed by a stale rvalid: outputs return to NOP_INSTR/RESET_PC and no word is delivered.

Source files
------------

// File: rtl/c_fetch.sv
// c_fetch: instruction-fetch front stage for the compressed-extension frontend.
//
// Owns the halfword-aligned fetch PC, issues word-aligned requests to
// instruction memory over a req/gnt/rvalid handshake and holds one fetched
// word plus its PC for the compressed realign/decode stage (c_top).
//
// Ports:
//   clk, reset_i          core clock, synchronous active-high reset
//   br_taken_i/target_i   branch/jump redirect (target bit 0 forced to 0)
//   ext_stall_i           downstream hazard; held word is not consumed
//   pc_half_i, stall_i,
//   pc_realigned_i        next-PC hints from c_top
//   imem_*                instruction memory req/gnt/rvalid handshake
//   pc_o, instr_o,
//   valid_o               held word, its PC, and whether it is live
module c_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        ext_stall_i,
  input  logic        pc_half_i,
  input  logic        stall_i,
  input  logic [31:0] pc_realigned_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StDeliver = 2'd3;

  localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFE;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;

  logic [31:0] target;
  logic [31:0] next_pc;
  logic        consume;

  assign target  = br_target_i & 32'hFFFF_FFFE;
  assign next_pc = stall_i ? (pc_realigned_i & 32'hFFFF_FFFE)
                           : pc_q + (pc_half_i ? 32'd2 : 32'd4);

  // The held word is consumed only when no redirect and no downstream hazard.
  assign consume = (state_q == StDeliver) && !br_taken_i && !ext_stall_i;

  // On consumption the next request goes out in the same cycle, so the address
  // comes straight from next_pc rather than waiting for fetch_addr_q to update.
  assign imem_req_o  = (state_q == StReq) || consume;
  assign imem_addr_o = (consume ? next_pc : fetch_addr_q) & 32'hFFFF_FFFC;

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    kill_d       = kill_q;

    case (state_q)
      StIdle: begin
        state_d = StReq;
        if (br_taken_i) fetch_addr_d = target;
      end

      StReq: begin
        if (br_taken_i) fetch_addr_d = target;
        if (imem_gnt_i) begin
          state_d = StWait;
          // Old address was granted together with a redirect: drop its response.
          kill_d  = br_taken_i;
        end
      end

      StWait: begin
        if (br_taken_i) begin
          fetch_addr_d = target;
          kill_d       = 1'b1;
        end
        if (imem_rvalid_i) begin
          // A redirect arriving with the response also makes the data stale.
          if (kill_q || br_taken_i) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d = imem_rdata_i;
            pc_d    = fetch_addr_q;
            valid_d = 1'b1;
            state_d = StDeliver;
          end
        end
      end

      StDeliver: begin
        if (br_taken_i) begin
          fetch_addr_d = target;
          valid_d      = 1'b0;
          instr_d      = NOP_INSTR;
          state_d      = StReq;
        end else if (!ext_stall_i) begin
          fetch_addr_d = next_pc;
          valid_d      = 1'b0;
          instr_d      = NOP_INSTR;
          state_d      = imem_gnt_i ? StWait : StReq;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= StIdle;
      fetch_addr_q <= ResetPcAligned;
      pc_q         <= ResetPcAligned;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      kill_q       <= kill_d;
    end
  end

endmodule

// File: tb/tb_c_fetch.sv
// Testbench for c_fetch: directed scenarios plus randomized traffic, checked
// against a transaction-level model of which word should be delivered next.
module tb_c_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        ext_stall_i;
  logic        pc_half_i;
  logic        stall_i;
  logic [31:0] pc_realigned_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;

  always #5 clk = ~clk;

  c_fetch dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .ext_stall_i   (ext_stall_i),
    .pc_half_i     (pc_half_i),
    .stall_i       (stall_i),
    .pc_realigned_i(pc_realigned_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory image: distinct per word, and word 0 holds 32'h0000_0093.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) ^ 32'h0000_0093;
  endfunction

  // Reference model: PC of the next word to deliver (or of the held word),
  // whether a live word is held, and the single outstanding memory response.
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic        pending;
  logic        stale;
  logic [31:0] pend_addr;
  int          cnt;
  int          lat_cfg;  // < 0: random response latency
  int          n_rv;
  int          n_deliv;

  // Outputs sampled in the most recent cycle.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  // Called at a falling edge: drives one cycle, checks it, updates the model,
  // then returns at the next falling edge.
  task automatic run_cycle(input logic br, input logic [31:0] tgt, input logic es,
                           input logic ph, input logic st, input logic [31:0] pr,
                           input logic gnt, input logic spur);
    logic        rv_real;
    logic        consume;
    logic        nv;
    logic [31:0] nxt;
    br_taken_i     = br;
    br_target_i    = tgt;
    ext_stall_i    = es;
    pc_half_i      = ph;
    stall_i        = st;
    pc_realigned_i = pr;
    imem_gnt_i     = gnt;
    rv_real        = 1'b0;
    if (pending && cnt == 0) begin
      rv_real       = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr);
    end else begin
      imem_rvalid_i = !pending && spur;
      imem_rdata_i  = $urandom;
      if (pending) cnt--;
    end
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = valid_o;
    s_pc = pc_o; s_instr = instr_o;

    check_eq("valid", valid_o, exp_valid);
    if (exp_valid) begin
      check_eq("pc", pc_o, exp_pc);
      check_eq("instr", instr_o, mem_word(exp_pc));
    end else begin
      check_eq("instr_nop", instr_o, Nop);
    end
    consume = exp_valid && !es && !br;
    nxt = st ? (pr & 32'hFFFF_FFFE) : exp_pc + (ph ? 32'd2 : 32'd4);
    if (pending || (exp_valid && (es || br))) check_eq("no_req", imem_req_o, 0);
    if (consume) check_eq("req_on_consume", imem_req_o, 1);
    if (imem_req_o) check_eq("req_addr", imem_addr_o, (consume ? nxt : exp_pc) & 32'hFFFF_FFFC);

    nv = (exp_valid && es && !br) || (rv_real && !stale && !br);
    if (rv_real) begin
      n_rv++;
      if (!stale && !br) n_deliv++;
      pending = 1'b0;
    end else if (pending && br) begin
      stale = 1'b1;
    end
    if (br) exp_pc = tgt & 32'hFFFF_FFFE;
    else if (consume) exp_pc = nxt;
    if (imem_req_o && gnt) begin
      pending   = 1'b1;
      stale     = br;
      pend_addr = imem_addr_o;
      cnt       = (lat_cfg < 0) ? int'($urandom_range(0, 2)) : lat_cfg;
    end
    exp_valid = nv;
    @(negedge clk);
  endtask

  // Any in-flight response is abandoned by reset.
  task automatic do_reset(input int cycles);
    reset_i = 1'b1;
    br_taken_i = 0; br_target_i = 0; ext_stall_i = 0; pc_half_i = 0; stall_i = 0;
    pc_realigned_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_req", imem_req_o, 0);
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_instr", instr_o, Nop);
    @(negedge clk);
    reset_i = 1'b0;
    exp_pc = 32'h0; exp_valid = 1'b0; pending = 1'b0; stale = 1'b0;
  endtask

  // Runs with the word held (ext_stall) until a live word appears, bounded.
  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!valid_o && k < max) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    check_eq({tag, "_arrive"}, valid_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hp, hi;
    int base;
    lat_cfg = 0; n_rv = 0; n_deliv = 0;
    do_reset(2);

    // Zero-wait memory from reset.
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("c0_req", s_req, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("c1_req", s_req, 1);
    check_eq("c1_addr", s_addr, 32'h0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("c2_valid", s_valid, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("c3_valid", s_valid, 1);
    check_eq("c3_pc", s_pc, 32'h0);
    check_eq("c3_instr", s_instr, 32'h0000_0093);
    check_eq("c3_addr", s_addr, 32'h4);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("c4_valid", s_valid, 0);
    run_cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check_eq("c5_valid", s_valid, 1);
    check_eq("c5_pc", s_pc, 32'h4);

    // Halfword step then full step.
    run_cycle(1, 32'h100, 1, 0, 0, 0, 0, 0);
    wait_valid("w100", 20);
    run_cycle(0, 0, 0, 1, 0, 0, 1, 0);
    check_eq("half_pc", s_pc, 32'h100);
    check_eq("half_addr", s_addr, 32'h100);
    wait_valid("w102", 20);
    check_eq("pc_102", pc_o, 32'h102);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("addr_104", s_addr, 32'h104);
    wait_valid("w106", 20);
    check_eq("pc_106", pc_o, 32'h106);

    // Realigned next address.
    run_cycle(1, 32'h202, 1, 0, 0, 0, 0, 0);
    wait_valid("w202", 20);
    run_cycle(0, 0, 0, 1, 1, 32'h204, 1, 0);
    check_eq("realign_addr", s_addr, 32'h204);
    wait_valid("w204", 20);
    check_eq("pc_204", pc_o, 32'h204);

    // Redirect while waiting: the returning word is dropped.
    lat_cfg = 1;
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    run_cycle(1, 32'h8001, 0, 0, 0, 0, 0, 0);
    check_eq("kill_valid0", s_valid, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("kill_valid1", s_valid, 0);
    lat_cfg = 0;
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("kill_valid2", s_valid, 0);
    check_eq("kill_req", s_req, 1);
    check_eq("kill_addr", s_addr, 32'h8000);
    wait_valid("w8000", 20);
    check_eq("pc_8000", pc_o, 32'h8000);
    check_eq("instr_8000", instr_o, mem_word(32'h8000));

    // Redirect coinciding with grant: one discarded response, then the target.
    run_cycle(1, 32'h400, 1, 0, 0, 0, 0, 0);
    base = n_rv;
    run_cycle(1, 32'h500, 0, 0, 0, 0, 1, 0);
    check_eq("bg_req", s_req, 1);
    check_eq("bg_addr", s_addr, 32'h400);
    wait_valid("w500", 20);
    check_eq("pc_500", pc_o, 32'h500);
    check_eq("bg_responses", n_rv - base, 2);

    // Downstream hazard holds everything with no request.
    hp = pc_o; hi = instr_o;
    repeat (5) begin
      run_cycle(0, 0, 1, 0, 0, 0, 1, 0);
      check_eq("hold_req", s_req, 0);
      check_eq("hold_valid", s_valid, 1);
      check_eq("hold_pc", s_pc, hp);
      check_eq("hold_instr", s_instr, hi);
    end

    // Address wrap.
    run_cycle(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0);
    wait_valid("wtop", 20);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("wrap_addr", s_addr, 32'h0);
    wait_valid("wwrap", 20);
    check_eq("wrap_pc", pc_o, 32'h0);

    // Reset during WAIT, then a stale response.
    lat_cfg = 2;
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("stale_valid", s_valid, 0);
    check_eq("stale_instr", s_instr, Nop);
    check_eq("stale_pc", s_pc, 32'h0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("stale_valid2", s_valid, 0);

    // Randomized traffic.
    lat_cfg = -1;
    base = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      run_cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) == 0,
                1'($urandom), $urandom_range(0, 7) == 0, $urandom,
                1'($urandom), $urandom_range(0, 15) == 0);
    end
    check_eq("rand_progress", n_deliv - base > 50, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
